// File: rtl/ddr_wr_burst_ctrl.sv
// rtl/ddr_wr_burst_ctrl.sv - FIFO-to-AXI write burst controller for one frame buffer
// Purpose: pops a read FIFO through a 2-entry skid buffer and writes the words out
//   as fixed-length AXI bursts at consecutive addresses until a frame is complete.
// Ports:
//   clk, tb_rst                        clock, async active-high reset
//   frame_start                        one-cycle pulse starting a frame
//   fifo_rd_data/fifo_rd_water_level   FIFO read data (1-cycle latency) and occupancy
//   fifo_rd_en                         FIFO pop
//   awaddr/awlen/awvalid/awready       AXI write-address channel
//   wdata/wlast/wvalid/wready          AXI write-data channel
//   bvalid/bready                      AXI write-response channel
//   busy, frame_done                   status: not idle / one-cycle end-of-frame pulse
module ddr_wr_burst_ctrl #(
  parameter int DATA_W                 = 128,
  parameter int LEVEL_W                = 11,
  parameter int BURST_LEN              = 16,
  parameter int ADDR_W                 = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int FRAME_BEATS            = 98304
) (
  input  logic               clk,
  input  logic               tb_rst,
  input  logic               frame_start,
  input  logic [DATA_W-1:0]  fifo_rd_data,
  input  logic [LEVEL_W-1:0] fifo_rd_water_level,
  output logic               fifo_rd_en,
  output logic [ADDR_W-1:0]  awaddr,
  output logic [7:0]         awlen,
  output logic               awvalid,
  input  logic               awready,
  output logic [DATA_W-1:0]  wdata,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic               bvalid,
  output logic               bready,
  output logic               busy,
  output logic               frame_done
);

  localparam int CNT_W = $clog2(FRAME_BEATS + 1);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(BURST_LEN * (DATA_W / 8));
  localparam logic [8:0]        BURST_N  = 9'(BURST_LEN);
  localparam logic [CNT_W-1:0]  BURST_C  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  FRAME_C  = CNT_W'(FRAME_BEATS);

  typedef enum logic [2:0] {IDLE, WAIT_LVL, ADDR, DATA, RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]  beat_cnt;
  logic              pending;
  logic [8:0]        pop_cnt;   // pops issued in the current burst
  logic [8:0]        hs_cnt;    // W handshakes completed in the current burst
  logic              inflight;  // a pop was issued last cycle, its data is on fifo_rd_data now
  logic [DATA_W-1:0] skid0, skid1;
  logic [1:0]        skid_cnt;

  logic       w_hs, last_burst, pend_now;
  logic [2:0] occ_after;

  assign wvalid     = (skid_cnt != 2'd0);
  assign wdata      = wvalid ? skid0 : '0;
  assign wlast      = wvalid && (hs_cnt == BURST_N - 9'd1);
  assign w_hs       = wvalid && wready;
  assign busy       = (state != IDLE);
  assign last_burst = (beat_cnt + BURST_C == FRAME_C);
  // A frame_start on the boundary cycle itself counts the same as a latched one.
  assign pend_now   = pending || frame_start;
  // Occupancy once this cycle's arrival and drain settle; counting the drain keeps
  // the pipe full with no bubbles while wready stays high.
  assign occ_after  = 3'(skid_cnt) + 3'(inflight) - 3'(w_hs);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    awvalid    = 1'b0;
    awaddr     = '0;
    awlen      = '0;
    bready     = 1'b0;
    case (state)
      IDLE:     if (frame_start) state_nxt = WAIT_LVL;
      WAIT_LVL: if (fifo_rd_water_level >= LEVEL_W'(BURST_LEN)) state_nxt = ADDR;
      ADDR: begin
        awvalid = 1'b1;
        awaddr  = next_addr;
        awlen   = 8'(BURST_LEN - 1);
        if (awready) state_nxt = DATA;
      end
      DATA: begin
        fifo_rd_en = (pop_cnt < BURST_N) && (occ_after < 3'd2);
        if (w_hs && wlast) state_nxt = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = (pend_now || !last_burst) ? WAIT_LVL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      next_addr  <= BASE_ADDR;
      beat_cnt   <= '0;
      pending    <= 1'b0;
      pop_cnt    <= '0;
      hs_cnt     <= '0;
      inflight   <= 1'b0;
      skid0      <= '0;
      skid1      <= '0;
      skid_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      frame_done <= (state == RESP) && bvalid && !pend_now && last_burst;

      if (state == ADDR)   pop_cnt <= '0;
      else if (fifo_rd_en) pop_cnt <= pop_cnt + 9'd1;

      if (state == ADDR) hs_cnt <= '0;
      else if (w_hs)     hs_cnt <= hs_cnt + 9'd1;

      case ({inflight, w_hs})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= fifo_rd_data;
          else                  skid1 <= fifo_rd_data;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) skid0 <= fifo_rd_data;
          else begin
            skid0 <= skid1;
            skid1 <= fifo_rd_data;
          end
        end
        default: ;
      endcase

      if (state == IDLE) begin
        if (frame_start) begin
          next_addr <= BASE_ADDR;
          beat_cnt  <= '0;
        end
      end else if (state == RESP && bvalid) begin
        pending <= 1'b0;
        if (pend_now) begin
          next_addr <= BASE_ADDR;
          beat_cnt  <= '0;
        end else begin
          next_addr <= next_addr + ADDR_INC;
          beat_cnt  <= beat_cnt + BURST_C;
        end
      end else if (frame_start) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// tb/tb_ddr_wr_burst_ctrl.sv - directed self-checking bench for ddr_wr_burst_ctrl
module tb_ddr_wr_burst_ctrl;

  logic         clk = 1'b0;
  logic         tb_rst;
  logic         frame_start;
  logic [127:0] fifo_rd_data;
  logic [10:0]  fifo_rd_water_level;
  logic         fifo_rd_en;
  logic [27:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid, awready;
  logic [127:0] wdata;
  logic         wlast, wvalid, wready;
  logic         bvalid, bready;
  logic         busy, frame_done;

  ddr_wr_burst_ctrl #(.FRAME_BEATS(64)) dut (
    .clk(clk), .tb_rst(tb_rst), .frame_start(frame_start),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_water_level(fifo_rd_water_level),
    .fifo_rd_en(fifo_rd_en), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  int cyc = 0, awv_cyc = 0, fd_cnt = 0, whs_cnt = 0, rd_cnt = 0, b_cnt = 0;
  int burst_beats = 0, first_cyc = 0, last_cyc = 0;
  int unsigned word_ctr = 1, exp_w = 1, avail = 0;
  logic         stall_prev = 1'b0;
  logic [127:0] stall_data = '0;
  int a0, r0, w0, f0;

  function automatic logic [127:0] word(input int unsigned i);
    return {4{i}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: sample outputs before the edge, then play the FIFO model after it.
  task automatic tick();
    logic rd;
    #1;
    fifo_rd_water_level = 11'(avail);
    #1;
    rd = fifo_rd_en;
    if (stall_prev) begin
      chk("w_hold_valid", 128'(wvalid), 128'd1);
      chk("w_hold_data", wdata, stall_data);
    end
    stall_prev = wvalid && !wready;
    stall_data = wdata;
    if (awvalid) awv_cyc++;
    if (frame_done) fd_cnt++;
    if (bvalid && bready) b_cnt++;
    if (rd) rd_cnt++;
    if (wvalid && wready) begin
      chk("wdata_order", wdata, word(exp_w));
      chk("wlast_pos", 128'(wlast), 128'(burst_beats == 15));
      exp_w++;
      if (burst_beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      burst_beats = (burst_beats == 15) ? 0 : burst_beats + 1;
      whs_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rd) begin
      fifo_rd_data = word(word_ctr);
      word_ctr++;
      avail--;
    end
    fifo_rd_water_level = 11'(avail);
    #1;
  endtask

  task automatic run_burst(input string tag, input bit rand_w);
    int b0;
    b0 = b_cnt;
    for (int i = 0; i < 400 && b_cnt == b0; i++) begin
      if (rand_w) wready = 1'($urandom_range(0, 1));
      tick();
    end
    wready = 1'b1;
    chk(tag, 128'(b_cnt - b0), 128'd1);
  endtask

  initial begin
    tb_rst = 1'b1; frame_start = 1'b0; fifo_rd_data = '0; fifo_rd_water_level = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("reset_outs", 128'({fifo_rd_en, awvalid, awaddr, awlen, wvalid, wlast, bready, busy, frame_done}), 128'd0);
    chk("reset_wdata", wdata, 128'd0);
    tb_rst = 1'b0;
    tick();

    // Level gating: 15 words is not enough for a burst.
    avail = 15;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'd1);
    a0 = awv_cyc; r0 = rd_cnt;
    repeat (50) tick();
    chk("gate_no_awvalid", 128'(awv_cyc - a0), 128'd0);
    chk("gate_no_pop", 128'(rd_cnt - r0), 128'd0);
    avail = 16; tick();
    chk("b1_awvalid", 128'(awvalid), 128'd1);
    chk("b1_awaddr", 128'(awaddr), 128'h000);
    chk("b1_awlen", 128'(awlen), 128'd15);

    // Basic burst, everything ready.
    w0 = whs_cnt; r0 = rd_cnt;
    run_burst("b1_done", 1'b0);
    chk("b1_beats", 128'(whs_cnt - w0), 128'd16);
    chk("b1_pops", 128'(rd_cnt - r0), 128'd16);
    chk("b1_no_bubble", 128'(last_cyc - first_cyc), 128'd15);

    // Burst 2 under random write backpressure.
    avail = 16; tick();
    chk("b2_awaddr", 128'({awvalid, awaddr}), 128'({1'b1, 28'h100}));
    w0 = whs_cnt; r0 = rd_cnt;
    run_burst("b2_done", 1'b1);
    chk("b2_beats", 128'(whs_cnt - w0), 128'd16);
    chk("b2_pops", 128'(rd_cnt - r0), 128'd16);

    // Burst 3 with address-channel stall.
    avail = 16; awready = 1'b0; tick();
    chk("b3_awaddr", 128'({awvalid, awaddr}), 128'({1'b1, 28'h200}));
    repeat (3) tick();
    chk("b3_aw_hold", 128'({awvalid, awaddr, awlen}), 128'({1'b1, 28'h200, 8'd15}));
    awready = 1'b1;
    run_burst("b3_done", 1'b1);

    // Burst 4 ends the 64-beat frame.
    avail = 16; tick();
    chk("b4_awaddr", 128'({awvalid, awaddr}), 128'({1'b1, 28'h300}));
    f0 = fd_cnt;
    run_burst("b4_done", 1'b0);
    tick(); tick();
    chk("frame_done_once", 128'(fd_cnt - f0), 128'd1);
    chk("idle_busy0", 128'(busy), 128'd0);

    // Mid-frame restart during burst 2.
    avail = 16;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    run_burst("r1_done", 1'b0);
    avail = 16; tick();
    chk("r2_awaddr", 128'({awvalid, awaddr}), 128'({1'b1, 28'h100}));
    repeat (4) tick();
    f0 = fd_cnt;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    run_burst("r2_done", 1'b0);
    chk("restart_busy", 128'(busy), 128'd1);
    avail = 16; tick();
    chk("restart_awaddr", 128'({awvalid, awaddr}), 128'({1'b1, 28'h000}));
    chk("restart_no_done", 128'(fd_cnt - f0), 128'd0);

    // Reset at beat 7 of this burst.
    w0 = whs_cnt;
    for (int i = 0; i < 60 && whs_cnt - w0 < 7; i++) tick();
    chk("rst_reach_beat7", 128'(whs_cnt - w0), 128'd7);
    tb_rst = 1'b1; #1;
    chk("rst_mid_outs", 128'({fifo_rd_en, awvalid, awaddr, awlen, wvalid, wlast, bready, busy, frame_done}), 128'd0);
    chk("rst_mid_wdata", wdata, 128'd0);
    repeat (3) tick();
    tb_rst = 1'b0; avail = 32;
    a0 = awv_cyc;
    repeat (20) tick();
    chk("post_rst_no_aw", 128'(awv_cyc - a0), 128'd0);
    chk("post_rst_idle", 128'(busy), 128'd0);
    exp_w = word_ctr; burst_beats = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    chk("post_rst_awaddr", 128'({awvalid, awaddr}), 128'({1'b1, 28'h000}));
    w0 = whs_cnt;
    run_burst("post_rst_done", 1'b0);
    chk("post_rst_beats", 128'(whs_cnt - w0), 128'd16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ddr_wr_burst_ctrl.md
DDR_WR_BURST_CTRL -- requirements
Module: ddr_wr_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 128, FIFO read-side and AXI write data width.
REQ-002 SHALL have parameter LEVEL_W, default 11, FIFO read water-level width (RD_DEPTH_WIDTH+1).
REQ-003 SHALL have parameter BURST_LEN, default 16, beats per AXI burst, range 1..256.
REQ-004 SHALL have parameter ADDR_W, default 28, AXI byte-address width.
REQ-005 SHALL have parameter BASE_ADDR, default 0, frame buffer start byte address.
REQ-006 SHALL have parameter FRAME_BEATS, default 98304, beats per frame; it is an integer multiple of BURST_LEN.
REQ-007 SHALL have port clk, input, 1: single clock, the FIFO read clock.
REQ-008 SHALL have port tb_rst, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port frame_start, input, 1: one-cycle pulse marking a new frame.
REQ-010 SHALL have port fifo_rd_data, input, DATA_W: FIFO read data, valid one cycle after fifo_rd_en.
REQ-011 SHALL have port fifo_rd_water_level, input, LEVEL_W: FIFO read-side occupancy in DATA_W words.
REQ-012 SHALL have port fifo_rd_en, output, 1: FIFO pop.
REQ-013 SHALL have ports awaddr (output, ADDR_W), awlen (output, 8), awvalid (output, 1) and awready (input, 1): AXI write-address channel.
REQ-014 SHALL have ports wdata (output, DATA_W), wlast (output, 1), wvalid (output, 1) and wready (input, 1): AXI write-data channel.
REQ-015 SHALL have ports bvalid (input, 1) and bready (output, 1): AXI write-response channel.
REQ-016 SHALL have ports busy (output, 1), high in any state except IDLE, and frame_done (output, 1), a one-cycle pulse.

Function
REQ-017 SHALL implement states IDLE, WAIT_LVL, ADDR, DATA and RESP.
REQ-018 SHALL transition IDLE->WAIT_LVL on frame_start, loading next_addr=BASE_ADDR and beat_cnt=0.
REQ-019 SHALL transition WAIT_LVL->ADDR when fifo_rd_water_level >= BURST_LEN.
REQ-020 SHALL hold awvalid=1, awaddr=next_addr and awlen=BURST_LEN-1 in ADDR, and go to DATA on the cycle awvalid&&awready.
REQ-021 SHALL hold awaddr and awlen stable while awvalid=1 and awready=0.
REQ-022 SHALL, in DATA, pop exactly BURST_LEN words per burst with fifo_rd_en, and assert fifo_rd_en only while the in-flight count plus the buffered count is < 2 (2-entry output skid buffer).
REQ-023 SHALL drive wvalid=1 whenever the skid buffer is non-empty, with wdata taken from the buffer head in FIFO order.
REQ-024 SHALL hold wdata and wvalid stable while wready=0.
REQ-025 SHALL count a beat on each wvalid&&wready, and assert wlast on beat BURST_LEN only.
REQ-026 SHALL, after the wlast handshake, go DATA->RESP and drive bready=1 in RESP until bvalid; the bresp value is ignored.
REQ-027 SHALL, on bvalid, set next_addr += BURST_LEN*(DATA_W/8), wrapping modulo 2^ADDR_W, and beat_cnt += BURST_LEN.
REQ-028 SHALL, on bvalid with beat_cnt reaching FRAME_BEATS, pulse frame_done for one cycle and go to IDLE; otherwise go to WAIT_LVL.
REQ-029 SHALL, on frame_start while busy, latch a pending flag and not abort the current burst.
REQ-030 SHALL, on the next burst boundary with the pending flag set (the RESP bvalid cycle), restart with next_addr=BASE_ADDR and beat_cnt=0, go to WAIT_LVL, clear pending, and not pulse frame_done.
REQ-031 SHALL treat frame_start arriving in IDLE on the same cycle frame_done is generated as a normal start.
REQ-032 SHALL never pop the FIFO outside DATA, and never pop more than BURST_LEN words per burst.
REQ-033 SHALL have zero bubble cycles between beats while wready=1 and the FIFO holds enough words.

Reset
REQ-034 SHALL, while tb_rst=1, place the FSM in IDLE and force next_addr=BASE_ADDR, beat_cnt=0, pending=0, skid buffer empty.
REQ-035 SHALL, while tb_rst=1, force all outputs to 0: fifo_rd_en, awvalid, awaddr, awlen, wvalid, wdata, wlast, bready, busy, frame_done.
REQ-036 SHALL abandon any burst in progress on a mid-operation reset, with no further handshakes until a new frame_start.

Verification
REQ-037 SHALL cover basic burst: frame_start, level=16, awready/wready/bvalid always 1 -> awaddr=0x0, awlen=15, 16 consecutive beats, wlast on beat 16, next awaddr=0x100.
REQ-038 SHALL cover level gating: level=15 held 50 cycles -> awvalid stays 0 and fifo_rd_en stays 0; level->16 -> awvalid next cycle.
REQ-039 SHALL cover backpressure: wready toggling 1-0-1 randomly -> wdata sequence equals FIFO order with no loss or duplication, and exactly 16 fifo_rd_en pulses per burst.
REQ-040 SHALL cover frame end: FRAME_BEATS=64 -> 4 bursts at 0x000/0x100/0x200/0x300, one frame_done pulse, then IDLE with busy=0.
REQ-041 SHALL cover mid-frame restart: frame_start during burst 2 -> burst 2 completes, next awaddr=BASE_ADDR, no frame_done pulse.
REQ-042 SHALL cover reset mid-burst: tb_rst asserted at beat 7 -> all outputs 0 at once; after release, no awvalid until frame_start.
